// File: rtl/vid_out_fmt_if.sv
// -----------------------------------------------------------------------------
// vid_out_fmt_if
//   Pixel line-FIFO read port seen by the video output formatter.
//
//   Signal map to the formatter's FIFO pins:
//     rd    -> O_fifo_rd     FIFO read strobe (formatter drives)
//     flush -> O_fifo_flush  one-cycle FIFO flush pulse (formatter drives)
//     data  -> I_fifo_data   8-bit grayscale pixel, valid one cycle after rd
//     empty -> I_fifo_empty  FIFO empty flag
//
//   Modports:
//     master : formatter side (drives rd/flush, samples data/empty)
//     slave  : FIFO side
// -----------------------------------------------------------------------------
interface vid_out_fmt_if;
  logic       rd;
  logic       flush;
  logic [7:0] data;
  logic       empty;

  modport master (output rd, output flush, input data, input empty);
  modport slave  (input rd, input flush, output data, output empty);
endinterface

// File: rtl/vid_out_fmt.sv
// -----------------------------------------------------------------------------
// vid_out_fmt
//   Video output formatter between the pixel line FIFO and the HDMI/DVI
//   encoder. Pulls 8-bit grayscale pixels during the sync generator's read
//   window and emits 24-bit RGB, with DE/HS/VS delayed to match (2 cycles).
//   DE pixels outside the read window get BORDER_COLOR. A read request that
//   meets an empty FIFO is an underflow event: it is flagged (sticky),
//   counted (saturating), the rest of the frame is filled with UFL_COLOR and
//   the FIFO is flushed and reading resumes at the next frame start.
//
//   Optional feature: define VIDOUT_TESTPAT_EN to add an 8-bar colour test
//   pattern selected by I_testpat (BAR_W pixels per bar). Without the macro
//   I_testpat is ignored.
//
//   Ports:
//     I_pxl_clk           pixel clock (only clock)
//     I_rst_n             synchronous active-low reset
//     I_rden              read-window strobe from the sync generator
//     I_de, I_hs, I_vs    display enable / syncs (HS_POL / VS_POL active)
//     I_testpat           select colour-bar pattern (macro builds only)
//     fifo                line-FIFO port (vid_out_fmt_if.master)
//     O_r, O_g, O_b       output pixel
//     O_de, O_hs, O_vs    syncs delayed to match the pixel
//     O_ufl               sticky underflow flag
//     O_ufl_cnt           underflow-event count, saturating at 255
// -----------------------------------------------------------------------------
module vid_out_fmt #(
  parameter bit          HS_POL       = 1'b1,
  parameter bit          VS_POL       = 1'b1,
  parameter logic [23:0] BORDER_COLOR = 24'h000000,
  parameter logic [23:0] UFL_COLOR    = 24'hFF0000,
  parameter int          BAR_W        = 80
) (
  input  logic                 I_pxl_clk,
  input  logic                 I_rst_n,
  input  logic                 I_rden,
  input  logic                 I_de,
  input  logic                 I_hs,
  input  logic                 I_vs,
  input  logic                 I_testpat,
  vid_out_fmt_if.master        fifo,
  output logic [7:0]           O_r,
  output logic [7:0]           O_g,
  output logic [7:0]           O_b,
  output logic                 O_de,
  output logic                 O_hs,
  output logic                 O_vs,
  output logic                 O_ufl,
  output logic [7:0]           O_ufl_cnt
);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    RUN      = 2'd1,
    RESYNC   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Frame-start detection: vs_prev_q holds the previous "VS active" sample.
  logic vs_act, vs_prev_q, sof;
  assign vs_act = (I_vs == VS_POL);
  assign sof    = vs_act & ~vs_prev_q;

  logic rd_c, flush_c, tag_c, evt_c;

  // Underflow bookkeeping
  logic       ufl_q;
  logic [7:0] ufl_cnt_q;

  // Stage 1: strobes captured alongside the FIFO read
  logic s1_rden_q, s1_de_q, s1_hs_q, s1_vs_q, s1_ufl_q, s1_rd_q;

  // Stage 2: output registers
  logic [23:0] rgb_q, pix_d;
  logic        de_q, hs_q, vs_q;

  // ---------------------------------------------------------------------------
  // Next-state / FIFO control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block
    // leaves a value held over, which would otherwise infer a latch.
    state_d = state_q;
    rd_c    = 1'b0;
    flush_c = 1'b0;
    tag_c   = 1'b0;
    evt_c   = 1'b0;
    unique case (state_q)
      WAIT_SOF: begin
        if (sof) state_d = RUN;
      end
      RUN: begin
        rd_c = I_rden & ~fifo.empty;
        if (I_rden & fifo.empty) begin
          tag_c   = 1'b1;
          evt_c   = 1'b1;
          state_d = RESYNC;
        end
      end
      RESYNC: begin
        // Everything in the read window is lost until the next frame start.
        tag_c = I_rden;
        if (sof) begin
          flush_c = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = WAIT_SOF;
    endcase
    // Strobes are combinational, so hold them off while reset is asserted.
    if (!I_rst_n) begin
      rd_c    = 1'b0;
      flush_c = 1'b0;
    end
  end

  assign fifo.rd    = rd_c;
  assign fifo.flush = flush_c;

  // ---------------------------------------------------------------------------
  // Test pattern (optional)
  // ---------------------------------------------------------------------------
`ifdef VIDOUT_TESTPAT_EN
  // Horizontal position tracked as (bar, pixel-within-bar) so no divider is
  // needed; the bar index stops at the last bar for over-long windows.
  logic [15:0] px_q;
  logic [2:0]  bar_q, s1_bar_q;
  logic        s1_tp_q;
  logic [23:0] bar_rgb;

  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst_n || !I_rden) begin
      px_q  <= '0;
      bar_q <= '0;
    end else if (bar_q != 3'd7) begin
      if (px_q == 16'(BAR_W - 1)) begin
        px_q  <= '0;
        bar_q <= bar_q + 3'd1;
      end else begin
        px_q <= px_q + 16'd1;
      end
    end
  end

  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst_n) begin
      s1_bar_q <= '0;
      s1_tp_q  <= 1'b0;
    end else begin
      s1_bar_q <= bar_q;
      s1_tp_q  <= I_testpat;
    end
  end

  always_comb begin
    unique case (s1_bar_q)
      3'd0:    bar_rgb = 24'hFFFFFF;  // white
      3'd1:    bar_rgb = 24'hFFFF00;  // yellow
      3'd2:    bar_rgb = 24'h00FFFF;  // cyan
      3'd3:    bar_rgb = 24'h00FF00;  // green
      3'd4:    bar_rgb = 24'hFF00FF;  // magenta
      3'd5:    bar_rgb = 24'hFF0000;  // red
      3'd6:    bar_rgb = 24'h0000FF;  // blue
      default: bar_rgb = 24'h000000;  // black
    endcase
  end
`else
  logic unused_testpat;
  assign unused_testpat = I_testpat;
  localparam int unused_bar_w = BAR_W;
`endif

  // ---------------------------------------------------------------------------
  // Colour select; FIFO data for a stage-1 read is valid in this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    pix_d = '0;
    if (!s1_de_q)
      pix_d = '0;
    else if (!s1_rden_q)
      pix_d = BORDER_COLOR;
    else if (s1_ufl_q)
      pix_d = UFL_COLOR;
`ifdef VIDOUT_TESTPAT_EN
    else if (s1_tp_q)
      pix_d = bar_rgb;
`endif
    else if (s1_rd_q)
      pix_d = {3{fifo.data}};
    else
      pix_d = '0;  // window pixel with no read issued (before first frame)
  end

  // ---------------------------------------------------------------------------
  // State, counters and pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge I_pxl_clk) begin
    // NOTE: reset is synchronous and clears the whole pipeline, so a reset
    // pulse mid-line shows idle syncs on the very next edge.
    if (!I_rst_n) begin
      state_q   <= WAIT_SOF;
      vs_prev_q <= 1'b0;
      ufl_q     <= 1'b0;
      ufl_cnt_q <= '0;
      s1_rden_q <= 1'b0;
      s1_de_q   <= 1'b0;
      s1_hs_q   <= ~HS_POL;
      s1_vs_q   <= ~VS_POL;
      s1_ufl_q  <= 1'b0;
      s1_rd_q   <= 1'b0;
      rgb_q     <= '0;
      de_q      <= 1'b0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
    end else begin
      // NOTE: non-blocking assignments so every register samples values from
      // before this edge, independent of statement order.
      state_q   <= state_d;
      vs_prev_q <= vs_act;
      if (evt_c) begin
        ufl_q <= 1'b1;
        if (ufl_cnt_q != 8'hFF) ufl_cnt_q <= ufl_cnt_q + 8'd1;
      end
      s1_rden_q <= I_rden;
      s1_de_q   <= I_de;
      s1_hs_q   <= I_hs;
      s1_vs_q   <= I_vs;
      s1_ufl_q  <= tag_c;
      s1_rd_q   <= rd_c;
      rgb_q     <= pix_d;
      de_q      <= s1_de_q;
      hs_q      <= s1_hs_q;
      vs_q      <= s1_vs_q;
    end
  end

  assign {O_r, O_g, O_b} = rgb_q;
  assign O_de      = de_q;
  assign O_hs      = hs_q;
  assign O_vs      = vs_q;
  assign O_ufl     = ufl_q;
  assign O_ufl_cnt = ufl_cnt_q;

endmodule

// File: tb/tb_vid_out_fmt.sv
// -----------------------------------------------------------------------------
// tb_vid_out_fmt
//   Scoreboard bench for vid_out_fmt. The stimulus process drives one pixel
//   per cycle, runs a frame-level reference model and pushes expected
//   control values (same cycle) and expected pixels (two cycles later) into
//   queues; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_vid_out_fmt;

  localparam bit          HS_POL = 1'b0;
  localparam bit          VS_POL = 1'b1;
  localparam logic [23:0] BORDER = 24'h102030;
  localparam logic [23:0] UFL    = 24'hFF0000;
  localparam int          BAR_W  = 80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rden, de, hs, vs, testpat;
  logic [7:0] o_r, o_g, o_b, o_cnt;
  logic       o_de, o_hs, o_vs, o_ufl;

  vid_out_fmt_if fif ();

  vid_out_fmt #(
    .HS_POL(HS_POL), .VS_POL(VS_POL),
    .BORDER_COLOR(BORDER), .UFL_COLOR(UFL), .BAR_W(BAR_W)
  ) dut (
    .I_pxl_clk(clk), .I_rst_n(rst_n), .I_rden(rden), .I_de(de),
    .I_hs(hs), .I_vs(vs), .I_testpat(testpat), .fifo(fif),
    .O_r(o_r), .O_g(o_g), .O_b(o_b), .O_de(o_de), .O_hs(o_hs), .O_vs(o_vs),
    .O_ufl(o_ufl), .O_ufl_cnt(o_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct { int cyc; bit rd; bit flush; bit ufl; int cnt; } ctl_t;
  typedef struct { int cyc; logic [23:0] rgb; bit de; bit hs; bit vs; } pix_t;
  typedef struct { bit rst; bit de; bit rden; bit hs; bit vs; bit tag; bit rd; bit tp; int x; } rec_t;

  ctl_t ctl_q[$];
  pix_t pix_q[$];

  // Reference model: "synced" = a frame start was seen since reset,
  // "lost" = the current frame has underflowed.
  bit   m_synced, m_lost, m_ufl, m_vs_prev;
  int   m_cnt, m_x;
  rec_t prev;

  function automatic logic [23:0] exp_rgb(input rec_t p, input logic [7:0] d);
    if (!p.de)   return 24'h0;
    if (!p.rden) return BORDER;
    if (p.tag)   return UFL;
`ifdef VIDOUT_TESTPAT_EN
    if (p.tp) begin : tp_blk
      int bi;
      bi = p.x / BAR_W;
      if (bi > 7) bi = 7;
      case (bi)
        0: return 24'hFFFFFF;
        1: return 24'hFFFF00;
        2: return 24'h00FFFF;
        3: return 24'h00FF00;
        4: return 24'hFF00FF;
        5: return 24'hFF0000;
        6: return 24'h0000FF;
        default: return 24'h000000;
      endcase
    end
`endif
    return p.rd ? {3{d}} : 24'h0;
  endfunction

  task automatic step(input bit rst, input bit rd_win, input bit de_i, input bit hs_i,
                      input bit vs_i, input bit emp, input bit tp);
    ctl_t c;
    pix_t p;
    rec_t rc;
    bit   vs_a, sof;
    @(posedge clk);
    #1;
    rst_n = rst; rden = rd_win; de = de_i; hs = hs_i; vs = vs_i;
    fif.empty = emp; testpat = tp; fif.data = 8'($urandom);

    c = '{cyc: cyc, rd: 1'b0, flush: 1'b0, ufl: m_ufl, cnt: m_cnt};
    rc = '{rst: rst, de: de_i, rden: rd_win, hs: hs_i, vs: vs_i, tag: 1'b0,
           rd: 1'b0, tp: tp, x: (rd_win ? m_x : 0)};
    vs_a = (vs_i == VS_POL);
    sof  = vs_a && !m_vs_prev;
    if (!rst) begin
      m_synced = 0; m_lost = 0; m_ufl = 0; m_cnt = 0; m_vs_prev = 0; m_x = 0;
    end else begin
      m_x = rd_win ? m_x + 1 : 0;
      if (!m_synced) begin
        if (sof) m_synced = 1;
      end else if (!m_lost) begin
        if (rd_win && emp) begin
          rc.tag = 1; m_ufl = 1; m_lost = 1;
          if (m_cnt < 255) m_cnt++;
        end else begin
          rc.rd = rd_win;
        end
      end else begin
        rc.tag = rd_win;
        if (sof) begin
          c.flush = 1; m_lost = 0;
        end
      end
      m_vs_prev = vs_a;
    end
    c.rd = rc.rd;
    ctl_q.push_back(c);

    // Pixel seen two cycles after its inputs; read data arrives this cycle.
    if (!prev.rst || !rst)
      p = '{cyc: cyc + 1, rgb: 24'h0, de: 1'b0, hs: !HS_POL, vs: !VS_POL};
    else
      p = '{cyc: cyc + 1, rgb: exp_rgb(prev, fif.data), de: prev.de, hs: prev.hs, vs: prev.vs};
    pix_q.push_back(p);
    prev = rc;
  endtask

  // One line: 6-cycle blanking with a 2-cycle HS pulse, then de_w pixels.
  task automatic line(input bit act, input bit vs_on, input int de_w, input int rd_off,
                      input int rd_w, input int ufl_px, input int empty_pct,
                      input bit tp, input int rst_px);
    bit vl;
    vl = vs_on ? VS_POL : !VS_POL;
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 1'b0, (i >= 1 && i < 3) ? HS_POL : !HS_POL, vl,
           1'($urandom_range(1)), tp);
    for (int i = 0; i < de_w; i++) begin
      bit rw, emp;
      rw  = act && i >= rd_off && i < rd_off + rd_w;
      emp = rw ? ((i - rd_off) == ufl_px || $urandom_range(99) < empty_pct)
               : 1'($urandom_range(1));
      step(i != rst_px, rw, act, !HS_POL, vl, emp, tp);
    end
  endtask

  task automatic frame(input int nlines, input int de_w, input int rd_off, input int rd_w,
                       input int ufl_line, input int ufl_px, input int empty_pct, input bit tp);
    for (int l = 0; l < 2; l++) line(1'b0, 1'b1, de_w, 0, 0, -1, 0, tp, -1);
    line(1'b0, 1'b0, de_w, 0, 0, -1, 0, tp, -1);
    for (int l = 0; l < nlines; l++)
      line(1'b1, 1'b0, de_w, rd_off, rd_w, (l == ufl_line) ? ufl_px : -1, empty_pct, tp, -1);
  endtask

  // Monitor
  initial begin
    ctl_t c;
    pix_t p;
    forever begin
      @(negedge clk);
      while (ctl_q.size() > 0 && ctl_q[0].cyc < cyc) begin
        n_err++;
        $display("FAIL ctl_stale: entry for cycle %0d not compared, now %0d", ctl_q[0].cyc, cyc);
        void'(ctl_q.pop_front());
      end
      while (pix_q.size() > 0 && pix_q[0].cyc < cyc) begin
        n_err++;
        $display("FAIL pix_stale: entry for cycle %0d not compared, now %0d", pix_q[0].cyc, cyc);
        void'(pix_q.pop_front());
      end
      if (ctl_q.size() > 0 && ctl_q[0].cyc == cyc) begin
        c = ctl_q.pop_front();
        check("fifo_rd",    fif.rd,    c.rd);
        check("fifo_flush", fif.flush, c.flush);
        check("ufl",        o_ufl,     c.ufl);
        check("ufl_cnt",    o_cnt,     c.cnt);
      end
      if (pix_q.size() > 0 && pix_q[0].cyc == cyc) begin
        p = pix_q.pop_front();
        check("rgb", {o_r, o_g, o_b}, p.rgb);
        check("de",  o_de, p.de);
        check("hs",  o_hs, p.hs);
        check("vs",  o_vs, p.vs);
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: stimulus did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; rden = 1'b0; de = 1'b0; hs = !HS_POL; vs = !VS_POL; testpat = 1'b0;
    fif.data = 8'h00; fif.empty = 1'b0;
    m_synced = 0; m_lost = 0; m_ufl = 0; m_vs_prev = 0; m_cnt = 0; m_x = 0;
    prev = '{rst: 1'b0, de: 1'b0, rden: 1'b0, hs: 1'b0, vs: 1'b0, tag: 1'b0,
             rd: 1'b0, tp: 1'b0, x: 0};

    repeat (3) step(1'b0, 1'b0, 1'b0, !HS_POL, !VS_POL, 1'b0, 1'b0);

    // No frame start yet: read window without reads, no underflow.
    repeat (2) line(1'b1, 1'b0, 800, 80, 640, -1, 0, 1'b0, -1);
    check("no_sof_ufl", o_ufl, 1'b0);

    // 640-pixel window inside 800-pixel DE, FIFO never empty.
    frame(3, 800, 80, 640, -1, -1, 0, 1'b0);

    // Empty FIFO at pixel 100 of line 5, then a clean frame after resync.
    frame(6, 800, 80, 640, 5, 100, 0, 1'b0);
    check("ufl_set", o_ufl, 1'b1);
    check("ufl_cnt_one", o_cnt, 8'd1);
    frame(2, 800, 80, 640, -1, -1, 0, 1'b0);
    check("ufl_cnt_still_one", o_cnt, 8'd1);

    // Randomized geometry and sporadic underflow.
    for (int f = 0; f < 15; f++) begin
      int dw, ro, rw;
      dw = $urandom_range(20, 60);
      ro = $urandom_range(0, 5);
      rw = $urandom_range(1, dw - ro);
      frame($urandom_range(1, 4), dw, ro, rw, -1, -1, 3 * $urandom_range(0, 1),
            1'($urandom_range(1)));
    end

    // One-cycle reset mid-line, then no reads until the next frame start.
    frame(1, 40, 0, 40, -1, -1, 0, 1'b0);
    line(1'b1, 1'b0, 40, 0, 40, -1, 0, 1'b0, 20);
    line(1'b1, 1'b0, 40, 0, 40, -1, 0, 1'b0, -1);
    check("rst_ufl_clear", o_ufl, 1'b0);
    check("rst_cnt_clear", o_cnt, 8'd0);
    frame(2, 40, 2, 30, -1, -1, 0, 1'b0);

    // 300 underflow frames: counter saturates.
    for (int f = 0; f < 300; f++) frame(1, 10, 1, 8, 0, 0, 0, 1'b0);
    check("cnt_saturated", o_cnt, 8'd255);

`ifdef VIDOUT_TESTPAT_EN
    frame(1, 800, 80, 640, -1, -1, 0, 1'b1);
`endif

    repeat (4) step(1'b1, 1'b0, 1'b0, !HS_POL, !VS_POL, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
